wb_port_arbiter: RTL
====================

# wb_port_arbiter

Arbiter for the single register-file write port at the end of the pipeline. It shares the port between the in-order write-back stream and results returning from a long-latency unit (multiplier/divider). Long-latency results go through a one-entry holding buffer. The pipeline has priority, but a starvation counter eventually stalls the pipeline for one cycle to drain the buffer. The arbiter sits between the write-back stage outputs and the register file.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- STARVE_MAX, 4, cycles a buffered result may lose arbitration before a stall is forced (1..7)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- we  in  1  pipeline advance enable; low = write-back stream frozen, its request ignored
- wb_data  in  DATA_W  write-back stage data
- wb_addr  in  ADDR_W  write-back stage destination register
- wb_write  in  1  write-back stage write request
- lu_valid  in  1  long-latency unit result valid
- lu_data  in  DATA_W  long-latency result data
- lu_addr  in  ADDR_W  long-latency destination register
- lu_ready  out  1  buffer can accept a result (combinational from state)
- stall_req  out  1  pipeline must not advance this cycle (combinational)
- rf_wdata  out  DATA_W  register-file write data (registered)
- rf_waddr  out  ADDR_W  register-file write address (registered)
- rf_we  out  1  register-file write enable (registered)

## Operation
- pipe_req = we & wb_write & (wb_addr != 0).
- Buffer: one entry {data, addr}, plus buf_valid.
- Load: lu_valid & lu_ready stores lu_data/lu_addr.
- lu_addr == 0: the handshake completes, but the entry is discarded and buf_valid stays 0.
- FSM states:
  - EMPTY: buf_valid=0, lu_ready=1, starve count held at 0.
  - WAIT: buf_valid=1, lu_ready=0.
  - FORCE: buf_valid=1, lu_ready=0, starve count == STARVE_MAX.
- Grant rules, evaluated each cycle:
  - EMPTY: pipe_req granted if set.
  - WAIT: pipe_req granted if set, otherwise the buffer is granted. Each cycle the buffer loses, the count increments. On reaching STARVE_MAX, next state is FORCE.
  - FORCE: the buffer is always granted. stall_req = pipe_req. The pipeline holds its write-back values and re-presents them next cycle. stall_req is 0 in EMPTY and WAIT.
- On a buffer grant: buf_valid clears next cycle, the count clears, and next state is EMPTY.
- WAW kill: in WAIT, a granted pipe write with wb_addr == buffered addr discards the buffer entry (next state EMPTY, count cleared). The pipeline write is the younger value.
- Transitions:
  - EMPTY->WAIT on accepted lu result with lu_addr != 0.
  - WAIT->FORCE on starve count reaching STARVE_MAX.
  - WAIT/FORCE->EMPTY on buffer grant or WAW kill.
- A result cannot be accepted in the same cycle the buffer drains (lu_ready = state==EMPTY).
- Starve count is 3 bits and never exceeds STARVE_MAX.

## Timing
- Write-port latency: one cycle. The grant in cycle N appears on rf_we/rf_waddr/rf_wdata in cycle N+1.
- No grant in cycle N means rf_we=0 in N+1. rf_wdata/rf_waddr hold their previous values.
- lu_ready and stall_req depend on current state and same-cycle inputs only. There is no path from lu_valid to lu_ready.
- Minimum buffered-result latency: accepted in N, granted in N+1, visible on rf_we in N+2.
- Worst case with continuous pipe_req: granted in N+1+STARVE_MAX with stall_req high that cycle.
- Reset: state EMPTY, buf_valid=0, count=0, rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0.
- lu_ready is forced 0 while reset is high.
- Reset mid-operation discards a buffered result without writing it.
- we=0: pipe_req=0, so a buffered entry is granted immediately. stall_req stays 0 because pipe_req=0.

## Test plan
- Pipe only: we=1, wb_write=1, wb_addr=3, wb_data=0xA5A5A5A5 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0xA5A5A5A5. Repeat with wb_addr=0 -> rf_we=0.
- Idle LU drain: lu_valid=1, lu_addr=7, lu_data=0x12345678, no pipe_req -> lu_ready falls next cycle; rf_we=1, rf_waddr=7, rf_wdata=0x12345678 two cycles after accept; lu_ready returns 1.
- Starvation: buffer addr=9, continuous pipe_req to addr=4, STARVE_MAX=4 -> four pipe writes; on the 5th cycle stall_req=1 and the buffer is granted; addr 9 is written next cycle; stall_req=0 after.
- WAW kill: buffer addr=5, pipe writes addr=5 data=0x1 -> only the pipe write appears; buffer entry never written; lu_ready=1 next cycle.
- Freeze drain: we=0 with buffer addr=2 -> buffer written next cycle, stall_req stays 0.
- Reset mid-WAIT: buffer holds addr=6, assert reset one cycle -> all outputs 0, lu_ready=0 during reset, then 1; addr 6 is never written.

Source files
------------

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Brief    : Shares the single register-file write port between the in-order
//            write-back stream and a one-entry buffer of long-latency results.
//            The pipeline wins arbitration; a starvation counter forces a
//            one-cycle pipeline stall so the buffered result can drain.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic              wb_write,
    input  logic              lu_valid,
    input  logic [DATA_W-1:0] lu_data,
    input  logic [ADDR_W-1:0] lu_addr,
    output logic              lu_ready,
    output logic              stall_req,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic              rf_we
);

    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_wait  = 2'd1;
    localparam logic [1:0] c_st_force = 2'd2;

    localparam logic [2:0] c_starve_max = 3'(STARVE_MAX);

    logic [1:0]        r_state;
    logic [2:0]        r_cnt;
    logic [DATA_W-1:0] r_buf_data;
    logic [ADDR_W-1:0] r_buf_addr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic              r_rf_we;

    logic [1:0]        w_state_nxt;
    logic [2:0]        w_cnt_nxt;
    logic [2:0]        w_cnt_inc;
    logic              w_pipe_req;
    logic              w_grant_pipe;
    logic              w_grant_buf;
    logic              w_load;

    // Pipeline request is ignored while frozen and for writes to register 0.
    assign w_pipe_req = we & wb_write & (wb_addr != '0);
    assign w_cnt_inc  = r_cnt + 3'd1;

    // Buffer accepts only when empty; held off while reset is asserted.
    assign lu_ready  = (r_state == c_st_empty) & ~reset;
    // Only a forced drain that collides with a live pipeline request stalls.
    assign stall_req = (r_state == c_st_force) & w_pipe_req;

    assign rf_wdata = r_rf_wdata;
    assign rf_waddr = r_rf_waddr;
    assign rf_we    = r_rf_we;

    // Grant selection, next-state and starvation-count logic.
    always_comb begin
        w_grant_pipe = 1'b0;
        w_grant_buf  = 1'b0;
        w_load       = 1'b0;
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            c_st_empty: begin
                w_grant_pipe = w_pipe_req;
                w_cnt_nxt    = 3'd0;
                // A result targeting register 0 completes its handshake but
                // is dropped without occupying the buffer.
                if (lu_valid && (lu_addr != '0)) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_st_wait;
                end
            end
            c_st_wait: begin
                if (w_pipe_req) begin
                    w_grant_pipe = 1'b1;
                    if (wb_addr == r_buf_addr) begin
                        // Younger pipeline write overwrites the same register,
                        // so the buffered value is dead.
                        w_state_nxt = c_st_empty;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_starve_max) begin
                            w_state_nxt = c_st_force;
                        end
                    end
                end else begin
                    w_grant_buf = 1'b1;
                    w_state_nxt = c_st_empty;
                    w_cnt_nxt   = 3'd0;
                end
            end
            c_st_force: begin
                w_grant_buf = 1'b1;
                w_state_nxt = c_st_empty;
                w_cnt_nxt   = 3'd0;
            end
            default: begin
                w_state_nxt = c_st_empty;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // State, starvation count and holding buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_empty;
            r_cnt      <= 3'd0;
            r_buf_data <= '0;
            r_buf_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load) begin
                r_buf_data <= lu_data;
                r_buf_addr <= lu_addr;
            end
        end
    end

    // Registered write port; address/data hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_grant_pipe | w_grant_buf;
            if (w_grant_pipe) begin
                r_rf_waddr <= wb_addr;
                r_rf_wdata <= wb_data;
            end else if (w_grant_buf) begin
                r_rf_waddr <= r_buf_addr;
                r_rf_wdata <= r_buf_data;
            end
        end
    end

endmodule
`default_nettype wire
